// File: rtl/cbg_lsu_responder_pkg.sv
// Shared sizes and op encoding for the CBG-side LSU responder.
package cbg_lsu_responder_pkg;
  localparam int N_LSU     = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int CNT_W_DEF = 16;
  localparam int IDX_W     = (N_LSU > 1) ? $clog2(N_LSU) : 1;

  localparam int R_Q     = N_LSU;
  localparam int W_Q     = N_LSU;
  localparam int A_bus   = N_LSU * ADDR_W;
  localparam int C_L_bus = N_LSU * DATA_W;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/cbg_lsu_responder_rr_arbiter.sv
// Round-robin arbiter: first pending request found searching circularly from rr_ptr.
module cbg_rr_arbiter
  import cbg_lsu_responder_pkg::*;
(
  input  logic [N_LSU-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_LSU-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_LSU; k++) begin
      pos = IDX_W'((int'(rr_ptr) + k) % N_LSU);
      if (!valid && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbg_lsu_responder.sv
// CBG responder: arbitrates LSU read/write requests onto a single-port word memory
// and returns registered read data on the granted LSU's slice.
module cbg_lsu_responder
  import cbg_lsu_responder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [R_Q-1:0]     R_request,
  input  logic [W_Q-1:0]     W_request,
  input  logic [A_bus-1:0]   LSU_addr_bus,
  input  logic [C_L_bus-1:0] LSU_wdata_bus,
  output logic [N_LSU-1:0]   grant,
  output logic [C_L_bus-1:0] CBG_to_LSU_bus,
  output logic [N_LSU-1:0]   rd_valid,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt
);

  logic [N_LSU-1:0]  req;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  gidx;
  logic              gvalid;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign req = R_request | W_request;

  cbg_rr_arbiter u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .idx    (gidx),
    .valid  (gvalid)
  );

  // Write wins when both are raised; the read stays pending for a later grant.
  always_comb begin
    op    = W_request[gidx] ? OP_WR : OP_RD;
    addr  = LSU_addr_bus[gidx*ADDR_W +: ADDR_W];
    wdata = LSU_wdata_bus[gidx*DATA_W +: DATA_W];
  end

  // Memory is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (gvalid && op == OP_WR) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr         <= '0;
      CBG_to_LSU_bus <= '0;
      rd_valid       <= '0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
    end else begin
      rd_valid <= '0;
      if (gvalid) begin
        rr_ptr <= (gidx == IDX_W'(N_LSU - 1)) ? '0 : gidx + 1'b1;
        if (op == OP_WR) begin
          if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
        end else begin
          CBG_to_LSU_bus[gidx*DATA_W +: DATA_W] <= mem[addr];
          rd_valid[gidx] <= 1'b1;
          if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cbg_lsu_responder.sv
// Self-checking bench for cbg_lsu_responder using a reference model and read scoreboard.
module tb_cbg_lsu_responder;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      R_request = '0;
  logic [N-1:0]      W_request = '0;
  logic [N*AW-1:0]   LSU_addr_bus = '0;
  logic [N*DW-1:0]   LSU_wdata_bus = '0;
  logic [N-1:0]      grant;
  logic [N*DW-1:0]   CBG_to_LSU_bus;
  logic [N-1:0]      rd_valid;
  logic [CW-1:0]     rd_cnt;
  logic [CW-1:0]     wr_cnt;

  cbg_lsu_responder #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .R_request      (R_request),
    .W_request      (W_request),
    .LSU_addr_bus   (LSU_addr_bus),
    .LSU_wdata_bus  (LSU_wdata_bus),
    .grant          (grant),
    .CBG_to_LSU_bus (CBG_to_LSU_bus),
    .rd_valid       (rd_valid),
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int lsu; logic [DW-1:0] data; } rd_t;
  rd_t q[$];

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]   ta [N];
  logic [DW-1:0]   tw [N];
  logic [DW-1:0]   m_mem [int];
  logic [DW-1:0]   m_bus [N];
  int              m_ptr = 0;
  int              m_rd = 0;
  int              m_wr = 0;
  logic [N-1:0]    exp_grant;
  logic [N-1:0]    exp_rv;
  logic [N*DW-1:0] exp_bus;

  function automatic logic [N*DW-1:0] pack_bus();
    logic [N*DW-1:0] b;
    for (int i = 0; i < N; i++) b[i*DW +: DW] = m_bus[i];
    return b;
  endfunction

  // Drive one cycle of requests and advance the reference model.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w);
    int g;
    rd_t e;
    R_request = r;
    W_request = w;
    for (int i = 0; i < N; i++) begin
      LSU_addr_bus[i*AW +: AW]  = ta[i];
      LSU_wdata_bus[i*DW +: DW] = tw[i];
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && (r[j] | w[j])) g = j;
    end
    exp_grant = '0;
    if (g >= 0) begin
      exp_grant[g] = 1'b1;
      if (w[g]) begin
        m_mem[int'(ta[g])] = tw[g];
        if (m_wr < MAXC) m_wr++;
      end else begin
        e.lsu  = g;
        e.data = m_mem.exists(int'(ta[g])) ? m_mem[int'(ta[g])] : '0;
        q.push_back(e);
        if (m_rd < MAXC) m_rd++;
      end
      m_ptr = (g + 1) % N;
    end
  endtask

  // Cross one clock edge; pop the scoreboard into the expected registered outputs.
  task automatic advance();
    rd_t e;
    @(posedge clk);
    #1;
    exp_rv = '0;
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_rv[e.lsu] = 1'b1;
      m_bus[e.lsu] = e.data;
    end
    exp_bus = pack_bus();
  endtask

  task automatic idle();
    drive('0, '0);
    advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 4'b0 || CBG_to_LSU_bus !== '0) begin
      errors++;
      $display("FAIL reset_out rd_valid=%b bus=%h required 0", rd_valid, CBG_to_LSU_bus);
    end
    checks++;
    if (rd_cnt !== '0 || wr_cnt !== '0 || grant !== '0) begin
      errors++;
      $display("FAIL reset_cnt rd=%0d wr=%0d grant=%b required 0", rd_cnt, wr_cnt, grant);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    ta[1] = 10'h005; tw[1] = 32'hDEADBEEF;
    drive(4'b0000, 4'b0010);
    #3;
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL wr_grant got=%b req=0010", grant); end
    advance();
    checks++;
    if (rd_valid !== 4'b0 || wr_cnt !== CW'(1)) begin
      errors++; $display("FAIL wr_commit rd_valid=%b wr_cnt=%0d req 0000/1", rd_valid, wr_cnt);
    end
    drive(4'b0010, 4'b0000);
    #3;
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL rd_grant got=%b req=0010", grant); end
    advance();
    checks++;
    if (rd_valid !== 4'b0010 || CBG_to_LSU_bus[DW +: DW] !== 32'hDEADBEEF || rd_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL raw_read rv=%b slice1=%h rd_cnt=%0d req 0010/deadbeef/1",
               rd_valid, CBG_to_LSU_bus[DW +: DW], rd_cnt);
    end
    idle();
    checks++;
    if (rd_valid !== 4'b0 || CBG_to_LSU_bus[DW +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_pulse rv=%b slice1=%h req 0000/deadbeef", rd_valid, CBG_to_LSU_bus[DW +: DW]);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [8];
    int pulses [N];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < N; i++) begin ta[i] = 10'h005; pulses[i] = 0; end
    // Grant LSU3 once so the pointer wraps to 0 before the sweep.
    drive(4'b1000, 4'b0000);
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 4'b0000);
      #3;
      checks++;
      if (grant !== seq[c] || grant !== exp_grant) begin
        errors++; $display("FAIL rr_grant cycle=%0d got=%b req=%b", c, grant, seq[c]);
      end
      advance();
      checks++;
      if (rd_valid !== exp_rv || CBG_to_LSU_bus !== exp_bus) begin
        errors++; $display("FAIL rr_data cycle=%0d rv=%b req=%b", c, rd_valid, exp_rv);
      end
      for (int i = 0; i < N; i++) if (rd_valid[i]) pulses[i]++;
    end
    idle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (pulses[i] != 2) begin errors++; $display("FAIL rr_pulses lsu=%0d got=%0d req=2", i, pulses[i]); end
    end
  endtask

  task automatic test_rw_collision();
    ta[2] = 10'h3FF; tw[2] = 32'h12345678;
    drive(4'b0100, 4'b0100);
    #3;
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL rw_grant got=%b req=0100", grant); end
    advance();
    checks++;
    if (rd_valid !== 4'b0 || wr_cnt !== CW'(m_wr)) begin
      errors++; $display("FAIL rw_write_first rv=%b wr_cnt=%0d req 0000/%0d", rd_valid, wr_cnt, m_wr);
    end
    drive(4'b0100, 4'b0000);
    advance();
    checks++;
    if (rd_valid !== 4'b0100 || CBG_to_LSU_bus[2*DW +: DW] !== 32'h12345678) begin
      errors++; $display("FAIL rw_read rv=%b slice2=%h req 0100/12345678", rd_valid, CBG_to_LSU_bus[2*DW +: DW]);
    end
    idle();
  endtask

  task automatic test_slice_hold();
    ta[0] = 10'h010; tw[0] = 32'hA5A5A5A5;
    ta[3] = 10'h011; tw[3] = 32'h5A5A5A5A;
    drive(4'b0000, 4'b1001);
    advance();
    drive(4'b0000, 4'b1001);
    advance();
    drive(4'b0001, 4'b0000);
    advance();
    checks++;
    if (rd_valid !== 4'b0001 || CBG_to_LSU_bus[0 +: DW] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL hold_rd0 rv=%b slice0=%h req 0001/a5a5a5a5", rd_valid, CBG_to_LSU_bus[0 +: DW]);
    end
    drive(4'b1000, 4'b0000);
    advance();
    checks++;
    if (rd_valid !== 4'b1000 || CBG_to_LSU_bus[3*DW +: DW] !== 32'h5A5A5A5A ||
        CBG_to_LSU_bus[0 +: DW] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL hold_rd3 rv=%b slice3=%h slice0=%h req 1000/5a5a5a5a/a5a5a5a5",
               rd_valid, CBG_to_LSU_bus[3*DW +: DW], CBG_to_LSU_bus[0 +: DW]);
    end
    checks++;
    if (CBG_to_LSU_bus !== exp_bus || rd_cnt !== CW'(m_rd) || wr_cnt !== CW'(m_wr)) begin
      errors++; $display("FAIL hold_model bus=%h req=%h rd=%0d wr=%0d", CBG_to_LSU_bus, exp_bus, rd_cnt, wr_cnt);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    ta[2] = 10'h005;
    drive(4'b0100, 4'b0000);
    #3;
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL mid_grant got=%b req=0100", grant); end
    rst = 1'b1;
    q.delete();
    m_ptr = 0; m_rd = 0; m_wr = 0;
    for (int i = 0; i < N; i++) m_bus[i] = '0;
    @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 4'b0 || CBG_to_LSU_bus !== '0 || rd_cnt !== '0 || wr_cnt !== '0) begin
      errors++; $display("FAIL mid_reset rv=%b bus=%h rd=%0d wr=%0d req all 0", rd_valid, CBG_to_LSU_bus, rd_cnt, wr_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) ta[i] = 10'h005;
    drive(4'b1111, 4'b0000);
    #3;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL mid_ptr got=%b req=0001", grant); end
    advance();
    checks++;
    if (rd_valid !== 4'b0001 || CBG_to_LSU_bus[0 +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mid_mem rv=%b slice0=%h req 0001/deadbeef", rd_valid, CBG_to_LSU_bus[0 +: DW]);
    end
    idle();
  endtask

  task automatic test_saturation();
    ta[1] = 10'h100;
    for (int i = 0; i < MAXC + 3; i++) begin
      tw[1] = 32'hC0DE_0000 + i;
      drive(4'b0000, 4'b0010);
      advance();
      checks++;
      if (wr_cnt !== CW'(m_wr)) begin errors++; $display("FAIL wr_sat step=%0d got=%0d req=%0d", i, wr_cnt, m_wr); end
    end
    checks++;
    if (wr_cnt !== 4'hF) begin errors++; $display("FAIL wr_sat_max got=%h req=f", wr_cnt); end
    for (int i = 0; i < MAXC + 3; i++) begin
      drive(4'b0010, 4'b0000);
      advance();
    end
    checks++;
    if (rd_cnt !== 4'hF || CBG_to_LSU_bus[DW +: DW] !== 32'hC0DE_0000 + MAXC + 2) begin
      errors++; $display("FAIL rd_sat got=%h slice1=%h req f/%h", rd_cnt, CBG_to_LSU_bus[DW +: DW], 32'hC0DE_0000 + MAXC + 2);
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin ta[i] = '0; tw[i] = '0; m_bus[i] = '0; end
    #2;
    test_reset();
    test_write_read();
    test_round_robin();
    test_rw_collision();
    test_slice_hold();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbg_lsu_responder.md
Name: cbg_lsu_responder

Overview:
- Memory-side responder for the LSU load/store protocol: the CBG end that services R_request/W_request/LSU_addr_bus from N_LSU LSUs and returns read data on CBG_to_LSU_bus.
- Round-robin arbitration grants one LSU per cycle to a single-port word memory.
- Read data is registered and returned to the granted LSU's slice with a one-cycle valid pulse.
- Sits between the PE rows' LSUs and the on-chip data buffer.

Parameters:
N_LSU, 4, number of LSU requesters
ADDR_W, 10, word address width; memory depth = 2**ADDR_W
DATA_W, 32, data word width
CNT_W, 16, width of saturating access counters

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
R_request  input  N_LSU  per-LSU read request, level, held until granted
W_request  input  N_LSU  per-LSU write request, level, held until granted
LSU_addr_bus  input  N_LSU*ADDR_W  per-LSU word address, slice i = [i*ADDR_W +: ADDR_W]
LSU_wdata_bus  input  N_LSU*DATA_W  per-LSU write data, slice i
grant  output  N_LSU  one-hot combinational grant, current cycle
CBG_to_LSU_bus  output  N_LSU*DATA_W  per-LSU registered read data, slice i
rd_valid  output  N_LSU  per-LSU one-cycle pulse, read data valid on slice
rd_cnt  output  CNT_W  saturating count of serviced reads
wr_cnt  output  CNT_W  saturating count of serviced writes

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- Reset values:
  - CBG_to_LSU_bus = 0, rd_valid = 0, rd_cnt = 0, wr_cnt = 0.
  - Round-robin pointer rr_ptr = 0.
  - Memory contents are not reset.
- Request vector: req[i] = R_request[i] | W_request[i].
- Arbitration (combinational):
  - grant = first i with req[i]=1, searching circularly from rr_ptr.
  - grant = 0 when no request is pending.
- Operation select for the granted LSU g: write if W_request[g], else read.
  - If R and W are both high, the write is serviced first. R stays pending and competes in later cycles.
- Pointer update at each clock edge with any grant: rr_ptr <= (g+1) mod N_LSU. No grant leaves rr_ptr unchanged.
- Write (cycle t): mem[addr_g] <= wdata_g at the edge ending t. No rd_valid is produced.
- Read (cycle t):
  - At the edge ending t, slice g of CBG_to_LSU_bus <= mem[addr_g] and rd_valid[g] <= 1.
  - Latency: data is visible in cycle t+1.
  - All other rd_valid bits are 0 in t+1.
  - Each slice holds its last read value until that LSU's next read.
- Read-after-write ordering: a read in cycle t+1 to the address written in cycle t returns the new data. Two accesses never occur in the same cycle.
- Handshake: the LSU drops the serviced request bit in the cycle after grant (or keeps it high for back-to-back ops). A request seen again is treated as a new op.
- Starvation bound: a continuously asserted request is granted within N_LSU cycles.
- Counters: rd_cnt/wr_cnt increment by 1 per serviced op and saturate at 2**CNT_W-1 (no wrap).
- Reset mid-operation: a pending read is dropped (rd_valid stays 0) and rr_ptr returns to 0. Memory keeps its contents, including a write committed at the last edge before reset.
- An address is always in range (depth = 2**ADDR_W).

Decomposition:
- Shared package/define file: N_LSU, ADDR_W, DATA_W alongside the existing bus-width defines (R_Q, W_Q, A_bus, C_L_bus). Op encoding constant: OP_RD=0, OP_WR=1.
- One sub-module: cbg_rr_arbiter (req[N_LSU], rr_ptr → one-hot grant + encoded index).
- Memory is an inferred single-port array inside the top.

Test Plan:
- Reset, then LSU1 writes 0xDEADBEEF to addr 0x005. Next cycle LSU1 reads 0x005 → grant=0010 both cycles; slice1=0xDEADBEEF, rd_valid=0010 one cycle later; wr_cnt=1, rd_cnt=1.
- All 4 LSUs hold R_request for 8 cycles with rr_ptr=0 → grant sequence 0001,0010,0100,1000,0001,…; each LSU gets exactly 2 rd_valid pulses.
- LSU2 asserts R and W together to addr 0x3FF with wdata 0x12345678 → write first (no rd_valid); following grant reads 0x12345678 on slice2.
- LSU0 reads addr 0x010 (preloaded 0xA5A5A5A5), then LSU3 reads 0x011 (0x5A5A5A5A) → slice0 still holds 0xA5A5A5A5 while slice3 updates.
- Assert rst in the cycle a read is granted → no rd_valid, all slices 0, rr_ptr=0; earlier-written data at 0x005 is still readable after reset.
- Force wr_cnt to 0xFFFE via 0xFFFE writes (or CNT_W=4 build, 14 writes), then 3 more writes → counter holds at max (0xFFFF / 0xF), no wrap.
